// File: rtl/burst_line_memory.sv
// ----------------------------------------------------------------------------
// burst_line_memory
//
// Behavioural main-memory model serving whole cache lines. One line request is
// accepted at a time. After LATENCY cycles the line is streamed as BURST_LEN
// beats, critical word first, wrapping within the line. Writes take the whole
// line on a wide data bus and commit one word per beat.
//
// Ports
//   clk         clock, all logic on the rising edge
//   rst         synchronous reset, active-high (array contents are kept)
//   mem_req     request, held until mem_ack
//   mem_addr    byte address, selects line and critical word
//   mem_we      1 = line write, 0 = line read
//   mem_wdata   write line, word offset j at [j*DATA_W +: DATA_W]
//   mem_ack     combinational accept (idle & mem_req & !rst)
//   mem_busy    transaction in progress
//   mem_rvalid  read beat valid
//   mem_rdata   read beat data (registered, holds between beats)
//   mem_rbeat   word offset within the line of the current read beat
//   mem_rlast   final read beat
//   mem_wdone   high during the final write beat
// ----------------------------------------------------------------------------
module burst_line_memory #(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned ADDR_W    = 32,
   parameter int unsigned DEPTH     = 1024,
   parameter int unsigned BURST_LEN = 4,
   parameter int unsigned LATENCY   = 3,
   localparam int unsigned BEAT_W   = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        mem_req,
   input  logic [ADDR_W-1:0]           mem_addr,
   input  logic                        mem_we,
   input  logic [DATA_W*BURST_LEN-1:0] mem_wdata,
   output logic                        mem_ack,
   output logic                        mem_busy,
   output logic                        mem_rvalid,
   output logic [DATA_W-1:0]           mem_rdata,
   output logic [BEAT_W-1:0]           mem_rbeat,
   output logic                        mem_rlast,
   output logic                        mem_wdone
);

   localparam int unsigned BO    = $clog2(DATA_W / 8);
   localparam int unsigned IDX_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;

   localparam logic [IDX_W-1:0]  OFF_MASK  = IDX_W'(BURST_LEN - 1);
   localparam logic [BEAT_W-1:0] BEAT_MASK = BEAT_W'(BURST_LEN - 1);
   localparam logic [BEAT_W-1:0] LAST_K    = BEAT_W'(BURST_LEN - 1);
   localparam logic [CNT_W-1:0]  WAIT_LAST = CNT_W'((LATENCY > 1) ? (LATENCY - 2) : 0);

   typedef enum logic [1:0] {
      StIdle,
      StWait,
      StBeat
   } state_e;

   state_e                      state_q;
   logic [IDX_W-1:0]            base_q;   // line base word index
   logic [BEAT_W-1:0]           off_q;    // word offset of the current beat
   logic [BEAT_W-1:0]           k_q;      // beat number within the burst
   logic [CNT_W-1:0]            wait_q;
   logic                        we_q;
   logic [DATA_W*BURST_LEN-1:0] wdata_q;

   // The array holds (data ^ index) so that an all-zero power-up image reads
   // back as mem[i] = i without any time-zero initialisation loop.
   logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

   logic [IDX_W-1:0]  req_idx;
   logic [IDX_W-1:0]  req_base;
   logic [BEAT_W-1:0] req_off;
   logic [BEAT_W-1:0] off_inc;
   logic [IDX_W-1:0]  cur_idx;
   logic [DATA_W-1:0] wr_word;

   // Next-beat launch: decided combinationally, captured into the output
   // registers at the edge that starts the beat.
   logic              load;
   logic              nxt_we;
   logic [BEAT_W-1:0] nxt_off;
   logic [BEAT_W-1:0] nxt_k;
   logic [IDX_W-1:0]  nxt_idx;
   logic [DATA_W-1:0] nxt_rdata;

   logic unused_addr;

   // Upper address bits alias and sub-word bits are ignored.
   assign unused_addr = ^mem_addr;

   assign req_idx  = mem_addr[BO +: IDX_W];
   assign req_base = req_idx & ~OFF_MASK;
   assign req_off  = BEAT_W'(req_idx & OFF_MASK);
   assign off_inc  = (off_q + BEAT_W'(1)) & BEAT_MASK;
   assign cur_idx  = base_q | IDX_W'(off_q);
   assign wr_word  = wdata_q[int'(off_q) * DATA_W +: DATA_W];

   assign mem_ack  = (state_q == StIdle) & mem_req & ~rst;
   assign mem_busy = (state_q != StIdle);

   always_comb begin
      load    = 1'b0;
      nxt_we  = we_q;
      nxt_off = off_q;
      nxt_k   = k_q;
      unique case (state_q)
         StIdle: begin
            if (mem_req && (LATENCY == 1)) begin
               load    = 1'b1;
               nxt_we  = mem_we;
               nxt_off = req_off;
               nxt_k   = '0;
            end
         end
         StWait: begin
            if (wait_q == WAIT_LAST) begin
               load  = 1'b1;
               nxt_k = '0;
            end
         end
         StBeat: begin
            if (k_q != LAST_K) begin
               load    = 1'b1;
               nxt_off = off_inc;
               nxt_k   = k_q + BEAT_W'(1);
            end
         end
         default: ;
      endcase
      nxt_idx   = ((state_q == StIdle) ? req_base : base_q) | IDX_W'(nxt_off);
      nxt_rdata = mem[nxt_idx] ^ DATA_W'(nxt_idx);
   end

   // Control FSM with registered beat outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         base_q     <= '0;
         off_q      <= '0;
         k_q        <= '0;
         wait_q     <= '0;
         we_q       <= 1'b0;
         wdata_q    <= '0;
         mem_rvalid <= 1'b0;
         mem_rlast  <= 1'b0;
         mem_wdone  <= 1'b0;
         mem_rdata  <= '0;
         mem_rbeat  <= '0;
      end else begin
         mem_rvalid <= 1'b0;
         mem_rlast  <= 1'b0;
         mem_wdone  <= 1'b0;
         if (load) begin
            off_q      <= nxt_off;
            k_q        <= nxt_k;
            mem_rvalid <= ~nxt_we;
            mem_rlast  <= ~nxt_we & (nxt_k == LAST_K);
            mem_wdone  <= nxt_we & (nxt_k == LAST_K);
            if (!nxt_we) begin
               mem_rdata <= nxt_rdata;
               mem_rbeat <= nxt_off;
            end
         end
         unique case (state_q)
            StIdle: begin
               if (mem_req) begin
                  base_q  <= req_base;
                  off_q   <= req_off;
                  k_q     <= '0;
                  wait_q  <= '0;
                  we_q    <= mem_we;
                  wdata_q <= mem_wdata;
                  state_q <= (LATENCY == 1) ? StBeat : StWait;
               end
            end
            StWait: begin
               wait_q <= wait_q + CNT_W'(1);
               if (wait_q == WAIT_LAST) begin
                  state_q <= StBeat;
               end
            end
            StBeat: begin
               if (k_q == LAST_K) begin
                  state_q <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // Write beats commit at the edge ending the beat; a reset on that edge
   // cancels the word.
   always_ff @(posedge clk) begin
      if (!rst && (state_q == StBeat) && we_q) begin
         mem[cur_idx] <= wr_word ^ DATA_W'(cur_idx);
      end
   end

endmodule
